// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM state
// encoding and the bit positions of the packed status-flag register.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_W     = 3;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter
// Iterative shift-add multiplier producing the low WIDTH bits of a product.
// One multiplier bit is consumed per cycle; a load on start is followed by
// exactly WIDTH iteration cycles, the last of which raises done for one cycle
// with the final product valid on that same cycle.
//
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        load operands (must not coincide with a running operation)
//   multiplicand WIDTH-bit operand
//   multiplier   WIDTH-bit operand
//   done         one-cycle pulse on the final iteration cycle
//   product      low WIDTH bits of multiplicand * multiplier (valid with done)
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_next;

  // Only the low WIDTH bits are kept, so the signed/unsigned distinction of
  // the operands does not matter here.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = (cnt_q == CNT_W'(1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= multiplicand;
      mplier_q <= multiplier;
      cnt_q    <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_next;
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle
// Parametrised ALU with a valid/ready handshake on both sides. FORWARD, ADD,
// AND, OR, SUB and zero-amount shifts complete on the accepting edge; MUL
// (WIDTH cycles) and non-zero shifts (one bit per cycle) iterate in BUSY.
// The result and flags are held in DONE until the consumer takes them.
//
// state | meaning
// IDLE  | ready for a request (in_ready = 1)
// BUSY  | iterating a MUL or a shift
// DONE  | result and flags presented (out_valid = 1)
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   operation request
//   in_ready   request can be accepted (IDLE only)
//   select     opcode
//   data1      operand 1, unsigned
//   data2      operand 2, two's complement; low SHAMT_W bits are the shift amount
//   out_valid  result available
//   out_ready  consumer takes the result
//   result     registered result
//   zero       result == 0
//   carry      ADD carry-out, SUB not-borrow
//   overflow   ADD/SUB signed overflow
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  alu_state_e state_q, state_d;

  logic [2:0]        op_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [SHAMT_W-1:0] shcnt_q;
  logic [WIDTH-1:0]  result_q;
  logic [FLAG_W-1:0] flags_q;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic               mul_start;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_product;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   alu_res;
  logic [FLAG_W-1:0]  alu_flags;

  logic [WIDTH-1:0]   shreg_next;
  logic               iter_done;
  logic [WIDTH-1:0]   iter_res;

  assign accept = in_valid && in_ready;
  assign shamt  = data2[SHAMT_W-1:0];

  // Single-cycle datapath, evaluated on the live inputs so the result can be
  // registered on the accepting edge.
  always_comb begin
    sum_ext   = {1'b0, data1} + {1'b0, data2};
    diff_ext  = {1'b0, data1} - {1'b0, data2};
    alu_res   = '0;
    alu_flags = '0;
    case (select)
      OP_FWD: alu_res = data2;
      OP_ADD: begin
        alu_res               = sum_ext[WIDTH-1:0];
        alu_flags[FLAG_CARRY] = sum_ext[WIDTH];
        alu_flags[FLAG_OVF]   = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                                (sum_ext[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND: alu_res = data1 & data2;
      OP_OR:  alu_res = data1 | data2;
      OP_SUB: begin
        alu_res               = diff_ext[WIDTH-1:0];
        // The extended difference borrows exactly when data1 < data2.
        alu_flags[FLAG_CARRY] = ~diff_ext[WIDTH];
        alu_flags[FLAG_OVF]   = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                                (diff_ext[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SLL, OP_SRA: alu_res = data1;  // zero-amount shift only
      default: alu_res = '0;
    endcase
    alu_flags[FLAG_ZERO] = (alu_res == '0);
  end

  // One bit position per BUSY cycle.
  assign shreg_next = (op_q == OP_SRA) ? {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]}
                                       : {shreg_q[WIDTH-2:0], 1'b0};

  assign iter_done = (op_q == OP_MUL) ? mul_done : (shcnt_q == SHAMT_W'(1));
  assign iter_res  = (op_q == OP_MUL) ? mul_product : shreg_next;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (mul_start),
    .multiplicand (data1),
    .multiplier   (data2),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (select == OP_MUL) begin
            state_d   = BUSY;
            mul_start = 1'b1;
          end else if (is_shift(select) && (shamt != '0)) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (iter_done) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_FWD;
      shreg_q  <= '0;
      shcnt_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= select;
            shreg_q <= data1;
            shcnt_q <= shamt;
            if (state_d == DONE) begin
              result_q <= alu_res;
              flags_q  <= alu_flags;
            end
          end
        end
        BUSY: begin
          if (op_q != OP_MUL) begin
            shreg_q <= shreg_next;
            shcnt_q <= shcnt_q - SHAMT_W'(1);
          end
          if (iter_done) begin
            result_q            <= iter_res;
            flags_q             <= '0;
            flags_q[FLAG_ZERO]  <= (iter_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign zero     = flags_q[FLAG_ZERO];
  assign carry    = flags_q[FLAG_CARRY];
  assign overflow = flags_q[FLAG_OVF];

endmodule
